// File: rtl/fb_fill_writer.sv
// Write-side engine for the 64x64 framebuffer: rectangle fill and full clear,
// one write per cycle while the display grants access, address = x*64 + y.
module fb_fill_writer #(
  parameter int COLOR_W   = 3,
  parameter int GRID_LOG2 = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_op,
  input  logic [GRID_LOG2-1:0]     cmd_x,
  input  logic [GRID_LOG2-1:0]     cmd_y,
  input  logic [GRID_LOG2:0]       cmd_w,
  input  logic [GRID_LOG2:0]       cmd_h,
  input  logic [COLOR_W-1:0]       cmd_color,
  input  logic                     wr_allow,
  output logic                     we,
  output logic [2*GRID_LOG2-1:0]   waddr,
  output logic [COLOR_W-1:0]       wdata,
  output logic                     busy,
  output logic                     done
);

  localparam logic [GRID_LOG2:0]   SIDE = {1'b1, {GRID_LOG2{1'b0}}};
  localparam logic [GRID_LOG2-1:0] ONE  = {{(GRID_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, state_next;

  logic [GRID_LOG2-1:0] cx, cy;
  logic [GRID_LOG2-1:0] y_start, x_end, y_end;
  logic [COLOR_W-1:0]   color;

  logic [GRID_LOG2-1:0] x0, y0, x_last, y_last;
  logic [GRID_LOG2:0]   room_x, room_y, w_eff, h_eff;
  logic                 accept, zero_size, col_end, last_cell;

  // Command decode and clipping against the right and bottom grid edges.
  always_comb begin
    x0     = cmd_op ? '0 : cmd_x;
    y0     = cmd_op ? '0 : cmd_y;
    room_x = SIDE - {1'b0, x0};
    room_y = SIDE - {1'b0, y0};
    w_eff  = cmd_op ? SIDE : ((cmd_w < room_x) ? cmd_w : room_x);
    h_eff  = cmd_op ? SIDE : ((cmd_h < room_y) ? cmd_h : room_y);
    // Modulo-64 sum is exact here because the clipped end never exceeds 63.
    x_last = x0 + w_eff[GRID_LOG2-1:0] - ONE;
    y_last = y0 + h_eff[GRID_LOG2-1:0] - ONE;
    zero_size = (w_eff == '0) || (h_eff == '0);
  end

  assign accept    = cmd_valid && cmd_ready;
  assign col_end   = (cy == y_end);
  assign last_cell = col_end && (cx == x_end);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && !zero_size) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (wr_allow && last_cell) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Ready is held low while reset is asserted so nothing is taken mid-reset.
  always_comb begin
    cmd_ready = (state == IDLE) && reset;
    busy      = (state == RUN);
  end

  // Walk the rectangle column by column, rows innermost; a stalled cycle holds everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cx      <= '0;
      cy      <= '0;
      y_start <= '0;
      x_end   <= '0;
      y_end   <= '0;
      color   <= '0;
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      done    <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            color   <= cmd_color;
            cx      <= x0;
            cy      <= y0;
            y_start <= y0;
            x_end   <= x_last;
            y_end   <= y_last;
            if (zero_size) begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (wr_allow) begin
            we    <= 1'b1;
            waddr <= {cx, cy};
            wdata <= color;
            if (col_end) begin
              cy <= y_start;
              if (last_cell) begin
                done <= 1'b1;
              end else begin
                cx <= cx + ONE;
              end
            end else begin
              cy <= cy + ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_fill_writer.sv
// Directed bench for fb_fill_writer: fills, clipping, stalls, zero size,
// full clear with a pending command, and reset in the middle of a fill.
module tb_fb_fill_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [5:0]  cmd_x = '0;
  logic [5:0]  cmd_y = '0;
  logic [6:0]  cmd_w = '0;
  logic [6:0]  cmd_h = '0;
  logic [2:0]  cmd_color = '0;
  logic        wr_allow = 1'b1;
  logic        we;
  logic [11:0] waddr;
  logic [2:0]  wdata;
  logic        busy;
  logic        done;

  fb_fill_writer #(.COLOR_W(3), .GRID_LOG2(6)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .wr_allow  (wr_allow),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  int compared = 0;
  int mismatched = 0;

  int   addr_q[$];
  int   done_edge, done_no_we, wdata_bad, order_err, ready_high, stall_we;
  logic [2:0] exp_color;
  logic acc_done, acc_busy, acc_ready, acc_we;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int q_at(input int i);
    return (i >= 0 && i < addr_q.size()) ? addr_q[i] : -1;
  endfunction

  // Present one command for a single edge, then record what the accept edge produced.
  task automatic applyStimulus(input logic op, input logic [5:0] x, input logic [5:0] y,
                               input logic [6:0] w, input logic [6:0] h, input logic [2:0] color);
    @(negedge clock);
    cmd_op    = op;
    cmd_x     = x;
    cmd_y     = y;
    cmd_w     = w;
    cmd_h     = h;
    cmd_color = color;
    cmd_valid = 1'b1;
    exp_color = color;
    @(negedge clock);
    cmd_valid = 1'b0;
    acc_done  = done;
    acc_busy  = busy;
    acc_ready = cmd_ready;
    acc_we    = we;
  endtask

  // Edge n counts from the accept edge; wr_allow is low for edges stall_lo..stall_hi.
  task automatic capture(input int budget, input int stall_lo, input int stall_hi);
    bit in_stall;
    addr_q.delete();
    done_edge  = -1;
    done_no_we = 0;
    wdata_bad  = 0;
    order_err  = 0;
    ready_high = 0;
    stall_we   = 0;
    for (int n = 1; n <= budget; n++) begin
      in_stall = (n >= stall_lo) && (n <= stall_hi);
      wr_allow = !in_stall;
      @(negedge clock);
      if (we) begin
        if (in_stall) stall_we++;
        if (addr_q.size() > 0 && int'(waddr) != addr_q[$] + 1) order_err++;
        addr_q.push_back(int'(waddr));
        if (wdata !== exp_color) wdata_bad++;
      end
      if (done) begin
        if (!we) done_no_we++;
        done_edge = n;
        break;
      end else if (cmd_ready) begin
        ready_high++;
      end
    end
    wr_allow = 1'b1;
  endtask

  initial begin
    // Reset state
    #23;
    checkOutput("rst_we", we, 0);
    checkOutput("rst_waddr", waddr, 0);
    checkOutput("rst_wdata", wdata, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_busy", busy, 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("rst_ready", cmd_ready, 1);

    // Basic 2x2 fill at (2,3)
    applyStimulus(1'b0, 6'd2, 6'd3, 7'd2, 7'd2, 3'd5);
    checkOutput("t1_acc_busy", acc_busy, 1);
    checkOutput("t1_acc_ready", acc_ready, 0);
    checkOutput("t1_acc_we", acc_we, 0);
    checkOutput("t1_acc_done", acc_done, 0);
    capture(20, 0, -1);
    checkOutput("t1_writes", addr_q.size(), 4);
    checkOutput("t1_a0", q_at(0), 131);
    checkOutput("t1_a1", q_at(1), 132);
    checkOutput("t1_a2", q_at(2), 195);
    checkOutput("t1_a3", q_at(3), 196);
    checkOutput("t1_wdata", wdata_bad, 0);
    checkOutput("t1_done_edge", done_edge, 4);
    checkOutput("t1_done_we", done_no_we, 0);
    @(negedge clock);
    checkOutput("t1_ready_after", cmd_ready, 1);
    checkOutput("t1_we_after", we, 0);
    checkOutput("t1_done_after", done, 0);

    // Clipped at the bottom-right corner
    applyStimulus(1'b0, 6'd63, 6'd62, 7'd3, 7'd3, 3'd2);
    capture(20, 0, -1);
    checkOutput("t2_writes", addr_q.size(), 2);
    checkOutput("t2_a0", q_at(0), 4094);
    checkOutput("t2_a1", q_at(1), 4095);
    checkOutput("t2_done_edge", done_edge, 2);
    checkOutput("t2_wdata", wdata_bad, 0);

    // 1x3 column with wr_allow low on edges 2..4
    applyStimulus(1'b0, 6'd0, 6'd0, 7'd1, 7'd3, 3'd6);
    capture(20, 2, 4);
    checkOutput("t3_stall_we", stall_we, 0);
    checkOutput("t3_writes", addr_q.size(), 3);
    checkOutput("t3_a0", q_at(0), 0);
    checkOutput("t3_a1", q_at(1), 1);
    checkOutput("t3_a2", q_at(2), 2);
    checkOutput("t3_done_edge", done_edge, 6);

    // Zero width: done on the accept edge, no writes
    applyStimulus(1'b0, 6'd4, 6'd4, 7'd0, 7'd5, 3'd1);
    checkOutput("t4_acc_done", acc_done, 1);
    checkOutput("t4_acc_we", acc_we, 0);
    checkOutput("t4_acc_ready", acc_ready, 1);
    checkOutput("t4_acc_busy", acc_busy, 0);
    @(negedge clock);
    checkOutput("t4_done_next", done, 0);
    checkOutput("t4_we_next", we, 0);

    // Full clear with rectangle fields that must be ignored, then a held 1x1 fill
    applyStimulus(1'b1, 6'd9, 6'd9, 7'd3, 7'd3, 3'd7);
    checkOutput("t5_acc_busy", acc_busy, 1);
    cmd_op    = 1'b0;
    cmd_x     = 6'd10;
    cmd_y     = 6'd20;
    cmd_w     = 7'd1;
    cmd_h     = 7'd1;
    cmd_color = 3'd3;
    cmd_valid = 1'b1;
    capture(5000, 0, -1);
    checkOutput("t5_writes", addr_q.size(), 4096);
    checkOutput("t5_first", q_at(0), 0);
    checkOutput("t5_last", q_at(addr_q.size() - 1), 4095);
    checkOutput("t5_order", order_err, 0);
    checkOutput("t5_wdata", wdata_bad, 0);
    checkOutput("t5_ready_busy", ready_high, 0);
    checkOutput("t5_done_edge", done_edge, 4096);
    exp_color = 3'd3;
    @(negedge clock);
    cmd_valid = 1'b0;
    checkOutput("t5_held_busy", busy, 1);
    checkOutput("t5_held_we", we, 0);
    capture(10, 0, -1);
    checkOutput("t5_held_writes", addr_q.size(), 1);
    checkOutput("t5_held_addr", q_at(0), 660);
    checkOutput("t5_held_wdata", wdata_bad, 0);
    checkOutput("t5_held_done", done_edge, 1);

    // Reset asserted mid-fill after 10 writes of an 8x8
    applyStimulus(1'b0, 6'd0, 6'd0, 7'd8, 7'd8, 3'd4);
    capture(10, 0, -1);
    checkOutput("t6_pre_writes", addr_q.size(), 10);
    checkOutput("t6_pre_done", done_edge, -1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6_rst_we", we, 0);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_done", done, 0);
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(1'b0, 6'd5, 6'd5, 7'd1, 7'd1, 3'd2);
    capture(20, 0, -1);
    checkOutput("t6_writes", addr_q.size(), 1);
    checkOutput("t6_addr", q_at(0), 325);
    checkOutput("t6_done_edge", done_edge, 1);
    @(negedge clock);
    checkOutput("t6_we_after", we, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fb_fill_writer.md
Name: fb_fill_writer

Overview:
- Write-side engine for the 64x64-cell display framebuffer; the VGA address generator is the read side.
- Accepts rectangle-fill and full-clear commands over a valid/ready handshake.
- Emits one framebuffer write per cycle, only while the display grants write access (wr_allow).
- Write address layout matches the read side: addr = x*64 + y, i.e. column stride 64, row step 1.

Parameters:
- COLOR_W, 3: width of the cell colour word written to the framebuffer.
- GRID_LOG2, 6: log2 of grid side; grid is 64x64, address width 2*GRID_LOG2 = 12.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  engine idle and able to accept a command.
- cmd_op  input  1  0 = fill rectangle, 1 = clear whole grid.
- cmd_x  input  6  rectangle left column.
- cmd_y  input  6  rectangle top row.
- cmd_w  input  7  width in cells, 0..64.
- cmd_h  input  7  height in cells, 0..64.
- cmd_color  input  COLOR_W  fill colour.
- wr_allow  input  1  framebuffer write permitted this cycle (e.g. vertical blank).
- we  output  1  framebuffer write enable.
- waddr  output  12  framebuffer write address.
- wdata  output  COLOR_W  framebuffer write data.
- busy  output  1  command in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async assert, low): state IDLE; we=0, waddr=0, wdata=0, done=0, busy=0. Counters cleared. cmd_ready=1 once reset deasserts.
- States:
  - IDLE: cmd_ready=1, busy=0.
  - RUN: cmd_ready=0, busy=1.
- Accept: on the edge where cmd_valid && cmd_ready.
  - Latch colour.
  - Load cx=x0, cy=y0.
  - Compute effective ew=min(w, 64-x0) and eh=min(h, 64-y0). This is clipping; use 7-bit arithmetic with no wrap.
  - For cmd_op=1, use x0=0, y0=0, ew=64, eh=64; cmd_x/y/w/h are ignored.
  - If ew==0 or eh==0: stay IDLE, pulse done=1 on that edge, no writes.
  - Otherwise go to RUN.
- RUN, each edge:
  - If wr_allow=1: we<=1, waddr<={cx,cy}, wdata<=colour, then advance.
  - If wr_allow=0: we<=0, counters hold (stall). There is no limit on stall length.
- Advance order is row-inner:
  - cy increments until cy == y0+eh-1.
  - Then cy<=y0 and cx increments.
  - The write at cx==x0+ew-1, cy==y0+eh-1 is the last one.
- Last write edge: state<=IDLE and done<=1 on the same edge, so done coincides with the final we cycle. done is 0 on all other edges.
- Throughput and timing:
  - One write per allowed cycle; total writes = ew*eh.
  - First write is registered on the first RUN edge with wr_allow=1, i.e. it appears no earlier than 1 cycle after accept.
- cmd_valid while busy: not accepted. The command stays pending for the initiator (standard valid/ready); the engine samples nothing.
- Address arithmetic: waddr = cx*64 + cy exactly, with no carry from cy into cx. After clipping, cx and cy never exceed 63.
- Reset mid-RUN: immediate abort to IDLE; we=0 and done=0 at once. Writes already issued are not undone.
- cmd_op=1 performs exactly 4096 writes, addresses 0..4095 in ascending order.

Test Plan:
- Fill x=2 y=3 w=2 h=2 colour=5, wr_allow=1 -> we for exactly 4 consecutive cycles, waddr 131,132,195,196, wdata=5, done high with the 4th write, cmd_ready=1 next cycle.
- Clip: x=63 y=62 w=3 h=3 -> 2 writes only, waddr 4094, 4095; done with the 2nd write.
- Stall: w=1 h=3 at (0,0), wr_allow low on cycles 2–4 after accept -> we low during the stall, addresses 0,1,2 each written once, in order, none skipped or duplicated.
- Zero size: w=0 h=5 -> done pulses on the accept edge, no we, cmd_ready stays 1.
- Clear colour=7 -> 4096 writes, first waddr 0, last waddr 4095, strictly incrementing by 1; a second cmd_valid held during the clear is accepted only after done.
- Reset low mid-fill (after 10 writes of an 8x8) -> we=0, busy=0, done=0 asynchronously; after release a new 1x1 fill at (5,5) writes waddr 325 only.
